// File: rtl/ddr5_bank_resp.sv
// Single-bank DDR5 responder: tracks bank state, enforces ACT/PRE/write-recovery timing, returns read strobes.
// Optional macro BANK_VIOL_CHECK_EN enables the sticky protocol-violation flag and captured code.
module ddr5_bank_resp #(
    parameter int unsigned t_act = 8,
    parameter int unsigned t_pre = 8,
    parameter int unsigned t_rl  = 4,
    parameter int unsigned t_wr  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cmd,
    output logic       busy,
    output logic       bank_open,
    output logic       rd_data_valid,
    output logic [7:0] rd_cnt,
    output logic       viol,
    output logic [3:0] viol_code
);

    typedef enum logic [1:0] {CLOSED, ACTIVATING, OPEN, PRECHARGING} state_t;
    typedef enum logic [3:0] {
        CMD_ACT = 4'b1000,
        CMD_RD  = 4'b0100,
        CMD_RDA = 4'b1100,
        CMD_WR  = 4'b0111,
        CMD_WRA = 4'b0101,
        CMD_PRE = 4'b1101
    } cmd_t;

    state_t          state, state_n;
    logic [7:0]      cnt, cnt_n;
    logic [7:0]      wr_cnt, wr_n;
    logic [t_rl-1:0] pipe, pipe_n;
    logic            ap, ap_n;
    logic            valid_n, busy_n, push, illegal;
    logic            is_act, is_rd, is_wr, is_pre, is_auto, is_nop;

    always_comb begin
        is_act  = (cmd == CMD_ACT);
        is_rd   = (cmd == CMD_RD) || (cmd == CMD_RDA);
        is_wr   = (cmd == CMD_WR) || (cmd == CMD_WRA);
        is_pre  = (cmd == CMD_PRE);
        is_auto = (cmd == CMD_RDA) || (cmd == CMD_WRA);
        is_nop  = !(is_act || is_rd || is_wr || is_pre);

        illegal = 1'b0;
        case (state)
            CLOSED:      illegal = is_rd || is_wr;
            ACTIVATING:  illegal = !is_nop;
            OPEN:        illegal = is_act || ((is_rd || is_wr) && ap) || (is_pre && (wr_cnt != '0));
            PRECHARGING: illegal = !is_nop;
            default:     illegal = 1'b0;
        endcase

        state_n = state;
        cnt_n   = cnt;
        ap_n    = ap;
        push    = 1'b0;
        wr_n    = (wr_cnt != '0) ? wr_cnt - 8'd1 : '0;

        case (state)
            CLOSED: begin
                if (is_act) begin
                    state_n = ACTIVATING;
                    cnt_n   = 8'(t_act - 1);
                end
            end
            ACTIVATING: begin
                if (cnt == '0) state_n = OPEN;
                else           cnt_n = cnt - 8'd1;
            end
            OPEN: begin
                if (!illegal) begin
                    push = is_rd;
                    if (is_wr)   wr_n = 8'(t_wr);
                    if (is_auto) ap_n = 1'b1;
                    if (is_pre) begin
                        state_n = PRECHARGING;
                        cnt_n   = 8'(t_pre - 1);
                        ap_n    = 1'b0;
                    end
                end
            end
            PRECHARGING: begin
                if (cnt == '0) state_n = CLOSED;
                else           cnt_n = cnt - 8'd1;
            end
            default: state_n = CLOSED;
        endcase

        pipe_n  = (pipe << 1) | t_rl'(push);
        valid_n = pipe[t_rl-1];

        // Auto-precharge looks at post-edge recovery/pipe values so it fires on the edge they drain.
        if (ap_n && (state_n == OPEN) && (wr_n == '0) && (pipe_n == '0)) begin
            state_n = PRECHARGING;
            cnt_n   = 8'(t_pre - 1);
            ap_n    = 1'b0;
        end

        busy_n = (state_n == ACTIVATING) || (state_n == PRECHARGING) || (pipe_n != '0)
               || valid_n || (wr_n != '0) || ap_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= CLOSED;
            cnt           <= '0;
            wr_cnt        <= '0;
            pipe          <= '0;
            ap            <= 1'b0;
            busy          <= 1'b0;
            bank_open     <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_cnt        <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            wr_cnt        <= wr_n;
            pipe          <= pipe_n;
            ap            <= ap_n;
            busy          <= busy_n;
            bank_open     <= (state_n == OPEN);
            rd_data_valid <= valid_n;
            rd_cnt        <= rd_cnt + 8'(valid_n);
        end
    end

`ifdef BANK_VIOL_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            viol      <= 1'b0;
            viol_code <= '0;
        end else if (!viol && illegal) begin
            viol      <= 1'b1;
            viol_code <= cmd;
        end
    end
`else
    assign viol      = 1'b0;
    assign viol_code = '0;
`endif

endmodule

// File: tb/tb_ddr5_bank_resp.sv
// Directed bench for ddr5_bank_resp: read strobes checked by a scoreboard monitor, state outputs checked inline.
module tb_ddr5_bank_resp;

    localparam logic [3:0] IDLE = 4'b0000, ACT = 4'b1000, RD = 4'b0100, RDA = 4'b1100;
    localparam logic [3:0] WR = 4'b0111, WRA = 4'b0101, PRE = 4'b1101;
`ifdef BANK_VIOL_CHECK_EN
    localparam int VCHK = 1;
`else
    localparam int VCHK = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cmd = 4'b0000;
    logic       busy, bank_open, rd_data_valid, viol;
    logic [7:0] rd_cnt;
    logic [3:0] viol_code;

    ddr5_bank_resp #(.t_act(8), .t_pre(8), .t_rl(4), .t_wr(4)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .busy(busy), .bank_open(bank_open),
        .rd_data_valid(rd_data_valid), .rd_cnt(rd_cnt), .viol(viol), .viol_code(viol_code)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_chk = 0;
    int n_pass = 0;
    int model_cnt = 0;

    typedef struct {int at; int cnt;} rd_exp_t;
    rd_exp_t sb[$];

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, edge_n);
    endtask

    task automatic tick(input logic [3:0] c);
        cmd = c;
        @(posedge clk);
        #1;
    endtask

    // Legal read: strobe expected t_rl=4 edges after the command edge.
    task automatic issue_rd(input logic [3:0] c);
        tick(c);
        model_cnt = (model_cnt + 1) % 256;
        sb.push_back('{edge_n + 4, model_cnt});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_open"}, bank_open, 0);
        check({tag, "_valid"}, rd_data_valid, 0);
        check({tag, "_rd_cnt"}, rd_cnt, 0);
        check({tag, "_viol"}, viol, 0);
        check({tag, "_code"}, viol_code, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_data_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", rd_data_valid, 0);
                end else begin
                    rd_exp_t e;
                    e = sb.pop_front();
                    check("strobe_edge", edge_n, e.at);
                    check("strobe_rd_cnt", rd_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int b;
        rst = 1'b0;
        tick(IDLE);
        tick(IDLE);
        check_all_zero("reset");
        rst = 1'b1;

        // ACT: busy through 7 edges, open at the 8th
        tick(ACT);
        check("act0_busy", busy, 1);
        check("act0_open", bank_open, 0);
        for (int k = 1; k <= 8; k++) begin
            tick(IDLE);
            check("act_busy", busy, (k < 8) ? 1 : 0);
            check("act_open", bank_open, (k == 8) ? 1 : 0);
        end
        tick(IDLE);

        // three back-to-back reads at relative edges 10,11,12
        issue_rd(RD);
        issue_rd(RD);
        issue_rd(RD);
        for (int k = 13; k <= 17; k++) begin
            tick(IDLE);
            if (k == 16) check("rd_busy16", busy, 1);
            if (k == 17) begin
                check("rd_busy17", busy, 0);
                check("rd_cnt3", rd_cnt, 3);
            end
        end

        // WRA: precharge after 4 recovery edges, closed 8 later
        tick(WRA);
        check("wra0_open", bank_open, 1);
        check("wra0_busy", busy, 1);
        for (int k = 1; k <= 12; k++) begin
            tick(IDLE);
            check("wra_open", bank_open, (k < 4) ? 1 : 0);
            check("wra_busy", busy, (k < 12) ? 1 : 0);
        end

        // RD while closed
        tick(RD);
        check("rdclosed_viol", viol, VCHK);
        check("rdclosed_code", viol_code, VCHK * 4);
        check("rdclosed_open", bank_open, 0);
        check("rdclosed_busy", busy, 0);
        tick(ACT);
        tick(ACT);
        check("act_in_act_code", viol_code, VCHK * 4);
        for (int k = 2; k <= 8; k++) tick(IDLE);
        check("reopen", bank_open, 1);

        // RDA then an RD that must be rejected
        issue_rd(RDA);
        tick(RD);
        tick(IDLE);
        tick(IDLE);
        check("rda3_open", bank_open, 1);
        tick(IDLE);
        check("rda4_open", bank_open, 0);
        check("rda4_busy", busy, 1);
        for (int k = 5; k <= 11; k++) tick(IDLE);
        check("rda11_busy", busy, 1);
        tick(IDLE);
        check("rda12_busy", busy, 0);
        check("rda12_open", bank_open, 0);
        check("rda_rd_cnt", rd_cnt, 4);

        // WR, early PRE rejected, PRE legal once recovery is done
        tick(ACT);
        for (int k = 1; k <= 8; k++) tick(IDLE);
        tick(WR);
        tick(PRE);
        check("early_pre_open", bank_open, 1);
        check("early_pre_busy", busy, 1);
        tick(IDLE);
        tick(IDLE);
        tick(IDLE);
        check("wr_rec_done_busy", busy, 0);
        tick(PRE);
        check("pre_open", bank_open, 0);
        check("pre_busy", busy, 1);
        for (int k = 1; k <= 7; k++) tick(IDLE);
        check("pre7_busy", busy, 1);
        tick(ACT);
        check("act_at_close_busy", busy, 0);
        check("act_at_close_open", bank_open, 0);
        check("act_at_close_code", viol_code, VCHK * 4);
        tick(IDLE);
        check("act_at_close_ignored", busy, 0);

        // reset in the middle of activation
        tick(ACT);
        tick(IDLE);
        tick(IDLE);
        rst = 1'b0;
        tick(IDLE);
        check_all_zero("midreset");
        model_cnt = 0;
        rst = 1'b1;
        tick(ACT);
        b = edge_n;
        for (int k = 1; k <= 8; k++) begin
            tick(IDLE);
            check("react_open", bank_open, (edge_n - b == 8) ? 1 : 0);
        end

        for (int k = 0; k < 6; k++) tick(IDLE);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
